// File: rtl/grant_stream_mux_pkg.sv
// grant_stream_mux_pkg
//   Shared types and helpers for the grant-driven stream multiplexer.
//   - state_t         : packet-ownership FSM states
//   - one_hot_or_zero : at most one bit set
//   - is_one_hot      : exactly one bit set
//   Vectors up to MAX_N bits are supported; callers zero-extend their
//   N-bit grant to MAX_N bits before calling.
package grant_stream_mux_pkg;

   localparam int MAX_N = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOCK    = 2'd1,
      DRAIN   = 2'd2,
      RELEASE = 2'd3
   } state_t;

   // Clearing the lowest set bit leaves zero only if at most one bit was set.
   function automatic logic one_hot_or_zero(input logic [MAX_N-1:0] v);
      return (v & (v - MAX_N'(1))) == '0;
   endfunction

   function automatic logic is_one_hot(input logic [MAX_N-1:0] v);
      return (v != '0) && one_hot_or_zero(v);
   endfunction

endpackage

// File: rtl/grant_stream_mux_one_hot_mux.sv
// one_hot_mux
//   Combinational AND-OR selector: picks one client's data/valid/last
//   using a one-hot (or all-zero) select vector. All-zero select yields
//   all-zero outputs.
// Ports
//   Sel        in   N     one-hot client select
//   Data       in   N*W   client data, client i in Data[i*W +: W]
//   Valid      in   N     per-client valid
//   Last       in   N     per-client last
//   Sel_Data   out  W     selected data
//   Sel_Valid  out  1     selected valid
//   Sel_Last   out  1     selected last
module one_hot_mux #(
   parameter int N = 2,
   parameter int W = 8
) (
   input  logic [N-1:0]   Sel,
   input  logic [N*W-1:0] Data,
   input  logic [N-1:0]   Valid,
   input  logic [N-1:0]   Last,
   output logic [W-1:0]   Sel_Data,
   output logic           Sel_Valid,
   output logic           Sel_Last
);

   // NOTE: every output of a combinational block gets a default before any
   // conditional logic, so no path leaves it unassigned and no latch appears.
   always_comb begin
      Sel_Data  = '0;
      Sel_Valid = 1'b0;
      Sel_Last  = 1'b0;
      for (int i = 0; i < N; i++) begin
         Sel_Data  = Sel_Data | (Data[i*W +: W] & {W{Sel[i]}});
         Sel_Valid = Sel_Valid | (Valid[i] & Sel[i]);
         Sel_Last  = Sel_Last | (Last[i] & Sel[i]);
      end
   end

endmodule

// File: rtl/grant_stream_mux.sv
// grant_stream_mux
//   Routes the byte stream of the client currently granted by the priority
//   arbiter onto a single shared sink. Ownership is latched for a whole
//   packet; Done pulses to the owner once its last beat has left the output
//   register, then the block waits for the arbiter to move Grant before
//   accepting a new owner. Error pulses on a multi-bit grant or on a grant
//   withdrawn mid-packet (the in-flight beat is discarded).
// Ports
//   Clk        in   1     system clock, rising edge
//   Reset      in   1     asynchronous, active-high
//   Grant      in   N     one-hot grant from arbiter (0 = no owner)
//   Data       in   N*W   client data, client i in Data[i*W +: W]
//   Valid      in   N     client i presents a beat
//   Last       in   N     client i's beat ends its packet
//   Ready      out  N     beat of client i accepted when Valid[i]&Ready[i]
//   Out_Data   out  W     registered sink data
//   Out_Valid  out  1     Out_Data holds a beat
//   Out_Last   out  1     beat on Out_Data ends the packet
//   Out_Ready  in   1     sink accepts when Out_Valid&Out_Ready
//   Done       out  N     one-cycle pulse to owner: packet delivered
//   Error      out  1     one-cycle pulse: bad grant or grant lost
module grant_stream_mux
   import grant_stream_mux_pkg::*;
#(
   parameter int N = 2,
   parameter int W = 8
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic [N-1:0]   Grant,
   input  logic [N*W-1:0] Data,
   input  logic [N-1:0]   Valid,
   input  logic [N-1:0]   Last,
   output logic [N-1:0]   Ready,
   output logic [W-1:0]   Out_Data,
   output logic           Out_Valid,
   output logic           Out_Last,
   input  logic           Out_Ready,
   output logic [N-1:0]   Done,
   output logic           Error
);

   state_t         state, state_nxt;
   logic [N-1:0]   owner, owner_nxt;
   logic [W-1:0]   data_nxt;
   logic           valid_nxt;
   logic           last_nxt;
   logic [N-1:0]   done_nxt;
   logic           error_nxt;

   logic [W-1:0]   sel_data;
   logic           sel_valid;
   logic           sel_last;
   logic           can_load;
   logic           grant_lost;

   one_hot_mux #(
      .N (N),
      .W (W)
   ) u_mux (
      .Sel       (owner),
      .Data      (Data),
      .Valid     (Valid),
      .Last      (Last),
      .Sel_Data  (sel_data),
      .Sel_Valid (sel_valid),
      .Sel_Last  (sel_last)
   );

   // Output register can take a new beat if empty or emptying this cycle.
   assign can_load   = ~Out_Valid | Out_Ready;
   assign grant_lost = ~|(Grant & owner);

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      data_nxt  = Out_Data;
      last_nxt  = Out_Last;
      valid_nxt = Out_Valid & ~Out_Ready;
      done_nxt  = '0;
      error_nxt = 1'b0;
      Ready     = '0;

      case (state)
         IDLE: begin
            if (is_one_hot(MAX_N'(Grant))) begin
               owner_nxt = Grant;
               state_nxt = LOCK;
            end else if (Grant != '0) begin
               error_nxt = 1'b1;
            end
         end

         LOCK: begin
            Ready = owner & {N{can_load}};
            // A withdrawn grant overrides a simultaneous accept: the beat
            // accepted this cycle and any beat still held are both dropped.
            if (grant_lost) begin
               error_nxt = 1'b1;
               valid_nxt = 1'b0;
               state_nxt = RELEASE;
            end else if (sel_valid && can_load) begin
               data_nxt  = sel_data;
               last_nxt  = sel_last;
               valid_nxt = 1'b1;
               if (sel_last) state_nxt = DRAIN;
            end
         end

         DRAIN: begin
            if (can_load) begin
               done_nxt  = owner;
               state_nxt = RELEASE;
            end
         end

         RELEASE: begin
            // The arbiter only re-arbitrates after the owner drops Request,
            // so any change of Grant means this packet is finished with.
            if (Grant != owner) begin
               owner_nxt = '0;
               state_nxt = IDLE;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         owner     <= '0;
         Out_Data  <= '0;
         Out_Valid <= 1'b0;
         Out_Last  <= 1'b0;
         Done      <= '0;
         Error     <= 1'b0;
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         Out_Data  <= data_nxt;
         Out_Valid <= valid_nxt;
         Out_Last  <= last_nxt;
         Done      <= done_nxt;
         Error     <= error_nxt;
      end
   end

endmodule

// File: tb/tb_grant_stream_mux.sv
module tb_grant_stream_mux;

   localparam int N = 2;
   localparam int W = 8;

   logic           Clk;
   logic           Reset;
   logic [N-1:0]   Grant;
   logic [N*W-1:0] Data;
   logic [N-1:0]   Valid;
   logic [N-1:0]   Last;
   logic [N-1:0]   Ready;
   logic [W-1:0]   Out_Data;
   logic           Out_Valid;
   logic           Out_Last;
   logic           Out_Ready;
   logic [N-1:0]   Done;
   logic           Error;

   typedef struct packed {
      logic [W-1:0] data;
      logic         last;
   } beat_t;

   beat_t        sb_q[$];
   int           total  = 0;
   int           passed = 0;
   logic [N-1:0] exp_owner = '0;

   grant_stream_mux #(.N(N), .W(W)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Grant     (Grant),
      .Data      (Data),
      .Valid     (Valid),
      .Last      (Last),
      .Ready     (Ready),
      .Out_Data  (Out_Data),
      .Out_Valid (Out_Valid),
      .Out_Last  (Out_Last),
      .Out_Ready (Out_Ready),
      .Done      (Done),
      .Error     (Error)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Monitor: pops the scoreboard on every sink handshake, checks that held
   // beats stay stable under backpressure, and checks per-cycle invariants.
   logic         hold_pend = 1'b0;
   logic [W-1:0] hold_data;
   logic         hold_last;

   always @(negedge Clk) begin
      beat_t b;
      if (Reset) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            check("hold_data", Out_Data, hold_data);
            check("hold_last", Out_Last, hold_last);
         end
         check("ready_single", ($countones(Ready) <= 1), 1);
         check("ready_owner", Ready & ~exp_owner, 0);
         check("done_error_excl", (Done != '0) && Error, 0);
         if (Out_Valid && Out_Ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_beat", Out_Data, 'hFFFF);
            end else begin
               b = sb_q.pop_front();
               check("beat_data", Out_Data, b.data);
               check("beat_last", Out_Last, b.last);
            end
         end
         hold_pend = Out_Valid && !Out_Ready;
         hold_data = Out_Data;
         hold_last = Out_Last;
      end
   end

   // Presents one beat from client c and waits (bounded) for acceptance.
   task automatic send_beat(input int c, input logic [W-1:0] d, input logic l, input bit push);
      int n;
      bit got;
      n   = 0;
      got = 1'b0;
      Data[c*W +: W] = d;
      Last[c]  = l;
      Valid[c] = 1'b1;
      while (n < 50 && !got) begin
         @(negedge Clk);
         if (Ready[c]) got = 1'b1;
         n++;
      end
      check("ready_timeout", got, 1);
      if (got && push) sb_q.push_back('{data: d, last: l});
      @(posedge Clk); #1;
      Valid[c] = 1'b0;
      Last[c]  = 1'b0;
   endtask

   // Waits (bounded) for a Done pulse, checks its value and 1-cycle width.
   task automatic wait_done(input logic [N-1:0] exp);
      int n;
      n = 0;
      do begin
         @(negedge Clk);
         n++;
      end while (Done == '0 && n < 20);
      check("done_value", Done, exp);
      @(negedge Clk);
      check("done_width", Done, 0);
   endtask

   task automatic idle_gap();
      @(posedge Clk); #1;
      Grant = '0;
      repeat (2) @(posedge Clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset     = 1'b1;
      Grant     = '0;
      Data      = '0;
      Valid     = '0;
      Last      = '0;
      Out_Ready = 1'b0;

      // Reset state
      @(negedge Clk);
      check("rst_ready", Ready, 0);
      check("rst_out_valid", Out_Valid, 0);
      check("rst_out_last", Out_Last, 0);
      check("rst_out_data", Out_Data, 0);
      check("rst_done", Done, 0);
      check("rst_error", Error, 0);
      @(posedge Clk); #1;
      Reset = 1'b0;

      // 1: three-beat packet from client 0, client 1 valid but ignored
      Grant = 2'b01; exp_owner = 2'b01; Out_Ready = 1'b1;
      Data[15:8] = 8'hEE; Valid[1] = 1'b1; Last[1] = 1'b1;
      send_beat(0, 8'hA1, 1'b0, 1'b1);
      send_beat(0, 8'hA2, 1'b0, 1'b1);
      send_beat(0, 8'hA3, 1'b1, 1'b1);
      @(negedge Clk);
      check("t1_a3_valid", Out_Valid, 1);
      check("t1_done_early", Done, 0);
      @(negedge Clk);
      check("t1_done", Done, 2'b01);
      check("t1_out_empty", Out_Valid, 0);
      @(negedge Clk);
      check("t1_done_clear", Done, 0);
      Valid[1] = 1'b0; Last[1] = 1'b0;
      idle_gap();

      // 2: backpressure for 4 cycles mid-packet
      Grant = 2'b01; exp_owner = 2'b01;
      send_beat(0, 8'hC1, 1'b0, 1'b1);
      Out_Ready = 1'b0;
      Data[7:0] = 8'hC2; Valid[0] = 1'b1;
      repeat (4) begin
         @(negedge Clk);
         check("t2_ready_bp", Ready[0], 0);
         check("t2_held_data", Out_Data, 8'hC1);
         check("t2_held_valid", Out_Valid, 1);
      end
      @(posedge Clk); #1;
      Out_Ready = 1'b1;
      send_beat(0, 8'hC2, 1'b0, 1'b1);
      send_beat(0, 8'hC3, 1'b1, 1'b1);
      wait_done(2'b01);
      idle_gap();

      // 3: client 1 packet, then arbiter moves grant to client 0
      Grant = 2'b10; exp_owner = 2'b10;
      send_beat(1, 8'hD1, 1'b0, 1'b1);
      send_beat(1, 8'hD2, 1'b1, 1'b1);
      wait_done(2'b10);
      @(posedge Clk); #1;
      Grant = 2'b01; exp_owner = 2'b01;
      Data[7:0] = 8'hE1; Valid[0] = 1'b1; Last[0] = 1'b1;
      @(negedge Clk);
      check("t3_release_ready", Ready, 0);
      @(negedge Clk);
      check("t3_idle_ready", Ready, 0);
      @(negedge Clk);
      check("t3_lock_ready", Ready, 2'b01);
      sb_q.push_back('{data: 8'hE1, last: 1'b1});
      @(posedge Clk); #1;
      Valid[0] = 1'b0; Last[0] = 1'b0;
      wait_done(2'b01);
      idle_gap();

      // 4: grant withdrawn while first beat is held -> discarded
      Grant = 2'b10; exp_owner = 2'b10; Out_Ready = 1'b0;
      send_beat(1, 8'hF1, 1'b0, 1'b0);
      Grant = 2'b00;
      @(negedge Clk);
      check("t4_held", Out_Valid, 1);
      check("t4_no_err_yet", Error, 0);
      @(negedge Clk);
      check("t4_error", Error, 1);
      check("t4_discard", Out_Valid, 0);
      check("t4_no_done", Done, 0);
      @(negedge Clk);
      check("t4_error_clear", Error, 0);
      check("t4_no_done2", Done, 0);
      @(posedge Clk); #1;
      Out_Ready = 1'b1;
      repeat (2) @(posedge Clk);
      #1;

      // 5: multi-bit grant
      Grant = 2'b11; exp_owner = 2'b00;
      @(negedge Clk);
      check("t5_ready", Ready, 0);
      check("t5_no_err_yet", Error, 0);
      @(posedge Clk); #1;
      Grant = 2'b00;
      @(negedge Clk);
      check("t5_error", Error, 1);
      check("t5_ready2", Ready, 0);
      @(negedge Clk);
      check("t5_error_clear", Error, 0);
      check("t5_still_idle", Ready, 0);

      // 6: asynchronous reset mid-packet, then a single-beat packet
      @(posedge Clk); #1;
      Grant = 2'b01; exp_owner = 2'b01; Out_Ready = 1'b0;
      send_beat(0, 8'h77, 1'b0, 1'b0);
      @(negedge Clk); #2;
      Reset = 1'b1;
      #1;
      check("t6_rst_valid", Out_Valid, 0);
      check("t6_rst_data", Out_Data, 0);
      check("t6_rst_last", Out_Last, 0);
      check("t6_rst_ready", Ready, 0);
      check("t6_rst_done", Done, 0);
      check("t6_rst_error", Error, 0);
      Out_Ready = 1'b1;
      @(negedge Clk);
      @(posedge Clk); #1;
      Reset = 1'b0;
      send_beat(0, 8'h5A, 1'b1, 1'b1);
      wait_done(2'b01);
      idle_gap();

      check("sb_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
